// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART transmitter types, frame encodings and helpers
// Optional feature macro: TX_BREAK_EN (adds the BREAK state).
package uart_pkg;

  // Data bits per frame: 00=5, 01=6, 10=7, 11=8
  typedef enum logic [1:0] {
    DW_5 = 2'b00,
    DW_6 = 2'b01,
    DW_7 = 2'b10,
    DW_8 = 2'b11
  } data_width_e;

  // Parity: even, odd, or none (both upper codes mean none)
  typedef enum logic [1:0] {
    PARITY_EVEN   = 2'b00,
    PARITY_ODD    = 2'b01,
    PARITY_NONE   = 2'b10,
    PARITY_NONE_B = 2'b11
  } parity_mode_e;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } stop_bits_e;

  typedef struct packed {
    data_width_e  data_width;
    parity_mode_e parity_mode;
    stop_bits_e   stop_bits;
  } uart_config_s;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
`ifdef TX_BREAK_EN
    , TX_BREAK
`endif
  } uart_tx_state_e;

  // Index of the last data bit for a given width (4 for 5 bits ... 7 for 8 bits)
  function automatic logic [2:0] last_bit_idx(input data_width_e w);
    return 3'd4 + {1'b0, w};
  endfunction

  // Parity is only sent for the even/odd codes
  function automatic logic has_parity(input parity_mode_e m);
    return !m[1];
  endfunction

  // Line value of the parity bit given the XOR of all data bits sent
  function automatic logic parity_bit(input parity_mode_e m, input logic xor_all);
    return (m == PARITY_ODD) ? ~xor_all : xor_all;
  endfunction

`ifdef TX_BREAK_EN
  // Break length in bit periods: start + data + parity + stop bits of the format
  function automatic logic [3:0] break_bits(input uart_config_s c);
    logic [3:0] n;
    n = 4'd6 + {2'b00, c.data_width};
    n = n + {3'b000, has_parity(c.parity_mode)};
    n = n + ((c.stop_bits == STOP_2) ? 4'd2 : 4'd1);
    return n;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - tick counter modulo OVERSAMPLE marking bit-period ends
module uart_tx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] count_q;

  // Count ticks, wrapping at the end of each bit period; clear restarts a period
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (tick_i) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign bit_end_o = tick_i && (count_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serialiser fed from the TX FIFO
// Optional feature macro: TX_BREAK_EN (send_break_i input and BREAK state).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic         enable_i,
  input  uart_config_s config_i,
  input  logic         tx_fifo_empty_i,
`ifdef TX_BREAK_EN
  input  logic         send_break_i,
`endif
  input  logic [7:0]   data_tx_i,
  output logic         tx_fifo_read_o,
  output logic         tx_o,
  output logic         busy_o,
  output logic         tx_done_o
);

  uart_tx_state_e state;
  uart_config_s   cfg_q;
  logic [7:0]     shift_q;
  logic [2:0]     bit_idx;
  logic           stop_left;
  logic           parity_acc;
  logic           bit_end;
  logic           timer_clear;
  logic           pop_go;
`ifdef TX_BREAK_EN
  logic [3:0]     break_left;
  logic           break_go;
  assign break_go = enable_i && send_break_i;
`endif

  // Timer is held at zero while idle and restarted in LOAD so START gets a full period
  assign timer_clear = (state == TX_IDLE) || (state == TX_LOAD);
  assign pop_go      = enable_i && !tx_fifo_empty_i;

  uart_tx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick_i   (tick_i),
    .clear_i  (timer_clear),
    .bit_end_o(bit_end)
  );

  // Frame sequencer: all line and handshake outputs registered here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= TX_IDLE;
      cfg_q          <= '0;
      shift_q        <= '0;
      bit_idx        <= '0;
      stop_left      <= 1'b0;
      parity_acc     <= 1'b0;
      tx_o           <= 1'b1;
      busy_o         <= 1'b0;
      tx_fifo_read_o <= 1'b0;
      tx_done_o      <= 1'b0;
`ifdef TX_BREAK_EN
      break_left     <= '0;
`endif
    end else begin
      tx_fifo_read_o <= 1'b0;
      tx_done_o      <= 1'b0;
      case (state)
        TX_IDLE: begin
`ifdef TX_BREAK_EN
          if (break_go) begin
            state      <= TX_BREAK;
            tx_o       <= 1'b0;
            busy_o     <= 1'b1;
            break_left <= break_bits(config_i);
          end else
`endif
          if (pop_go) begin
            tx_fifo_read_o <= 1'b1;
            busy_o         <= 1'b1;
            state          <= TX_FETCH;
          end
        end

        TX_FETCH: begin
          state <= TX_LOAD;
        end

        TX_LOAD: begin
          shift_q <= data_tx_i;
          cfg_q   <= config_i;
          tx_o    <= 1'b0;
          state   <= TX_START;
        end

        TX_START: begin
          if (bit_end) begin
            tx_o       <= shift_q[0];
            bit_idx    <= '0;
            parity_acc <= 1'b0;
            state      <= TX_DATA;
          end
        end

        TX_DATA: begin
          if (bit_end) begin
            parity_acc <= parity_acc ^ shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
            if (bit_idx == last_bit_idx(cfg_q.data_width)) begin
              if (has_parity(cfg_q.parity_mode)) begin
                tx_o  <= parity_bit(cfg_q.parity_mode, parity_acc ^ shift_q[0]);
                state <= TX_PARITY;
              end else begin
                tx_o      <= 1'b1;
                stop_left <= (cfg_q.stop_bits == STOP_2);
                state     <= TX_STOP;
              end
            end else begin
              tx_o    <= shift_q[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        TX_PARITY: begin
          if (bit_end) begin
            tx_o      <= 1'b1;
            stop_left <= (cfg_q.stop_bits == STOP_2);
            state     <= TX_STOP;
          end
        end

        TX_STOP: begin
          if (bit_end) begin
            if (stop_left) begin
              stop_left <= 1'b0;
            end else begin
              tx_done_o <= 1'b1;
`ifdef TX_BREAK_EN
              if (break_go) begin
                state      <= TX_BREAK;
                tx_o       <= 1'b0;
                break_left <= break_bits(config_i);
              end else
`endif
              if (pop_go) begin
                tx_fifo_read_o <= 1'b1;
                state          <= TX_FETCH;
              end else begin
                busy_o <= 1'b0;
                state  <= TX_IDLE;
              end
            end
          end
        end

`ifdef TX_BREAK_EN
        TX_BREAK: begin
          if (bit_end) begin
            if (break_left == 4'd1) begin
              tx_o      <= 1'b1;
              stop_left <= 1'b0;
              state     <= TX_STOP;
            end else begin
              break_left <= break_left - 4'd1;
            end
          end
        end
`endif

        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          state  <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam uart_config_s CFG_8N1 = '{data_width: DW_8, parity_mode: PARITY_NONE, stop_bits: STOP_1};
  localparam uart_config_s CFG_7E2 = '{data_width: DW_7, parity_mode: PARITY_EVEN, stop_bits: STOP_2};
  localparam uart_config_s CFG_5O1 = '{data_width: DW_5, parity_mode: PARITY_ODD, stop_bits: STOP_1};
  localparam uart_config_s CFG_6E1 = '{data_width: DW_6, parity_mode: PARITY_EVEN, stop_bits: STOP_1};

  logic         clk = 1'b0;
  logic         rst_i;
  logic         tick_i;
  logic         enable_i;
  uart_config_s config_i;
  logic         tx_fifo_empty_i;
  logic         send_break_i;
  logic [7:0]   data_tx_i = 8'h00;
  logic         tx_fifo_read_o;
  logic         tx_o;
  logic         busy_o;
  logic         tx_done_o;

  logic [7:0] fifo_mem [0:31];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int rd_count = 0;
  int done_count = 0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  assign tx_fifo_empty_i = (rd_ptr == wr_ptr);

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .tick_i         (tick_i),
    .enable_i       (enable_i),
    .config_i       (config_i),
    .tx_fifo_empty_i(tx_fifo_empty_i),
`ifdef TX_BREAK_EN
    .send_break_i   (send_break_i),
`endif
    .data_tx_i      (data_tx_i),
    .tx_fifo_read_o (tx_fifo_read_o),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .tx_done_o      (tx_done_o)
  );

  // FIFO model with one-cycle read latency, plus strobe counters
  always @(posedge clk) begin
    if (tx_fifo_read_o) begin
      data_tx_i <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
    rd_count   <= rd_count + int'(tx_fifo_read_o);
    done_count <= done_count + int'(tx_done_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  // Finds the start bit, then checks every cycle of each 16-cycle bit period
  task automatic check_frame(input logic [15:0] bits, input int nbits, input string tag,
                             output int gap);
    int   n;
    logic ok;
    n = 0;
    while (tx_o !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    chk({tag, "_start"}, 32'(n < 400), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      ok = 1'b1;
      for (int c = 0; c < 16; c++) begin
        if (tx_o !== bits[b]) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, b), {31'b0, ok}, 32'd1);
    end
  endtask

  initial begin
    int   gap;
    int   rd0;
    int   dn0;
    int   n;
    logic ok;

    rst_i        = 1'b1;
    tick_i       = 1'b1;
    enable_i     = 1'b0;
    send_break_i = 1'b0;
    config_i     = CFG_8N1;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'b0, tx_o}, 32'd1);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_read", {31'b0, tx_fifo_read_o}, 32'd0);
    chk("reset_done", {31'b0, tx_done_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // T1: 8N1 0xA5
    rd0 = rd_count;
    dn0 = done_count;
    push(8'hA5);
    enable_i = 1'b1;
    check_frame(16'h034A, 10, "t1", gap);
    chk("t1_done_pulse", {31'b0, tx_done_o}, 32'd1);
    chk("t1_busy_end", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    chk("t1_done_single", {31'b0, tx_done_o}, 32'd0);
    chk("t1_reads", 32'(rd_count - rd0), 32'd1);
    chk("t1_dones", 32'(done_count - dn0), 32'd1);

    // T2: 7E2 0x53
    config_i = CFG_7E2;
    push(8'h53);
    check_frame(16'h06A6, 11, "t2", gap);
    chk("t2_done_pulse", {31'b0, tx_done_o}, 32'd1);

    // T3: 5O1 0xFF, upper bits never sent
    config_i = CFG_5O1;
    push(8'hFF);
    check_frame(16'h00BE, 8, "t3", gap);
    chk("t3_done_pulse", {31'b0, tx_done_o}, 32'd1);
    ok = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (tx_o !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk("t3_idle_high", {31'b0, ok}, 32'd1);

    // T4: back-to-back 0x01, 0x02
    config_i = CFG_8N1;
    rd0 = rd_count;
    dn0 = done_count;
    push(8'h01);
    push(8'h02);
    check_frame(16'h0202, 10, "t4a", gap);
    chk("t4_busy_between", {31'b0, busy_o}, 32'd1);
    chk("t4_done_first", {31'b0, tx_done_o}, 32'd1);
    check_frame(16'h0204, 10, "t4b", gap);
    chk("t4_gap_cycles", 32'(gap), 32'd2);
    chk("t4_done_second", {31'b0, tx_done_o}, 32'd1);
    @(negedge clk);
    chk("t4_reads", 32'(rd_count - rd0), 32'd2);
    chk("t4_dones", 32'(done_count - dn0), 32'd2);

    // T5: reset pulse mid-DATA
    push(8'h00);
    n = 0;
    while (tx_o !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start", 32'(n < 400), 32'd1);
    repeat (40) @(negedge clk);
    chk("t5_mid_low", {31'b0, tx_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("t5_rst_tx", {31'b0, tx_o}, 32'd1);
    chk("t5_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("t5_rst_done", {31'b0, tx_done_o}, 32'd0);
    rst_i = 1'b0;
    dn0 = done_count;
    ok = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (tx_o !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk("t5_line_idle", {31'b0, ok}, 32'd1);
    chk("t5_no_done", 32'(done_count - dn0), 32'd0);
    push(8'h01);
    check_frame(16'h0202, 10, "t5_next", gap);

    // enable low holds the FIFO, then the byte goes out
    @(negedge clk);
    enable_i = 1'b0;
    rd0 = rd_count;
    push(8'h80);
    repeat (20) @(negedge clk);
    chk("en_low_reads", 32'(rd_count - rd0), 32'd0);
    chk("en_low_busy", {31'b0, busy_o}, 32'd0);
    enable_i = 1'b1;
    check_frame(16'h0300, 10, "en_frame", gap);

    // T6: config change mid-frame affects only the next frame
    config_i = CFG_8N1;
    push(8'h3C);
    push(8'h15);
    fork
      begin
        check_frame(16'h0278, 10, "t6a", gap);
        check_frame(16'h01AA, 9, "t6b", gap);
      end
      begin
        repeat (40) @(negedge clk);
        config_i = CFG_6E1;
      end
    join
    chk("t6_done_pulse", {31'b0, tx_done_o}, 32'd1);

`ifdef TX_BREAK_EN
    config_i = CFG_8N1;
    repeat (4) @(negedge clk);
    rd0 = rd_count;
    send_break_i = 1'b1;
    @(negedge clk);
    send_break_i = 1'b0;
    check_frame(16'h0400, 11, "brk", gap);
    chk("brk_done", {31'b0, tx_done_o}, 32'd1);
    chk("brk_no_pop", 32'(rd_count - rd0), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
